// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port byte-lane Memory between the
// instruction-fetch (IF) and load/store (LS) requesters. At most one grant per
// cycle. The granted request drives the Memory directly. The 1-cycle registered
// response is then routed back to the requester that owns it.
// Build option: define MEMARB_ROUND_ROBIN_EN for alternating arbitration.
// The default build uses LS priority with an IF starvation guard.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [1:0]  i_ls_wr_mask,
  input  logic [2:0]  i_ls_rd_mask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_err_misaligned,
  output logic        o_ls_err_rdmask,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_err_misaligned,
  input  logic        i_mem_err_rdmask
);

  localparam logic [2:0] RD_MASK_XX = 3'd5;

  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_LS} rsp_t;

  rsp_t state_reg, state_next;
  logic ls_xx_reg, ls_xx_next;   // in-flight LS access carried rd_mask XX
  logic if_gnt, ls_gnt;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_ls_reg, last_ls_next;   // 1 = LS received the most recent grant

  // Alternate on a tie. A lone requester always wins. Reset suppresses grants.
  always_comb begin
    if_gnt       = 1'b0;
    ls_gnt       = 1'b0;
    last_ls_next = last_ls_reg;
    if (!i_reset) begin
      if (i_if_req && i_ls_req) begin
        if_gnt = last_ls_reg;
        ls_gnt = !last_ls_reg;
      end else begin
        if_gnt = i_if_req;
        ls_gnt = i_ls_req;
      end
    end
    if (if_gnt)
      last_ls_next = 1'b0;
    else if (ls_gnt)
      last_ls_next = 1'b1;
  end

  // Last-grant register; resets to IF so LS wins the first tie.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      last_ls_reg <= 1'b0;
    else
      last_ls_reg <= last_ls_next;
  end
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             if_force;

  // LS wins unless IF has been held off STARVE_LIMIT cycles in a row.
  always_comb begin
    if_force = i_if_req && (starve_cnt_reg == CNT_MAX);
    ls_gnt   = !i_reset && i_ls_req && !if_force;
    if_gnt   = !i_reset && i_if_req && !ls_gnt;
    if (i_if_req && !if_gnt)
      starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? starve_cnt_reg
                                                    : starve_cnt_reg + CNT_W'(1);
    else
      starve_cnt_next = '0;
  end

  // Count of consecutive denied IF request cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      starve_cnt_reg <= '0;
    else
      starve_cnt_reg <= starve_cnt_next;
  end
`endif

  assign o_if_gnt = if_gnt;
  assign o_ls_gnt = ls_gnt;

  // Drive the Memory from the granted request. When idle, use a side-effect-free access.
  always_comb begin
    o_mem_address = 32'd0;
    o_mem_wr_data = 32'd0;
    o_mem_wr_mask = 2'd0;
    o_mem_rd_mask = RD_MASK_XX;
    if (ls_gnt) begin
      o_mem_address = i_ls_addr;
      o_mem_wr_data = i_ls_wdata;
      o_mem_wr_mask = i_ls_wr_mask;
      o_mem_rd_mask = i_ls_rd_mask;
    end else if (if_gnt) begin
      o_mem_address = i_if_addr;
      o_mem_rd_mask = 3'd0;
    end
  end

  // Next owner of the Memory response is whoever is granted this cycle.
  always_comb begin
    state_next = RSP_NONE;
    if (if_gnt)
      state_next = RSP_IF;
    else if (ls_gnt)
      state_next = RSP_LS;
    ls_xx_next = ls_gnt && (i_ls_rd_mask == RD_MASK_XX);
  end

  // Response-owner register; reset drops any in-flight response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= RSP_NONE;
      ls_xx_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ls_xx_reg <= ls_xx_next;
    end
  end

  // Route the Memory response and errors to the owner only.
  always_comb begin
    o_if_rvalid         = 1'b0;
    o_if_rdata          = 32'd0;
    o_ls_rvalid         = 1'b0;
    o_ls_rdata          = 32'd0;
    o_ls_err_misaligned = 1'b0;
    o_ls_err_rdmask     = 1'b0;
    case (state_reg)
      RSP_IF: begin
        o_if_rvalid = 1'b1;
        o_if_rdata  = i_mem_rd_data;
      end
      RSP_LS: begin
        o_ls_rvalid         = 1'b1;
        o_ls_rdata          = ls_xx_reg ? 32'd0 : i_mem_rd_data;
        o_ls_err_misaligned = i_mem_err_misaligned;
        o_ls_err_rdmask     = i_mem_err_rdmask;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It contains a small byte-lane Memory that the
// DUT drives. A transaction-level reference (shadow memory, grant rules) predicts
// grants, Memory drive and routed responses for directed and random traffic.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam logic [31:0] JUNK = 32'hA5A5A5A5;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [1:0]  i_ls_wr_mask;
  logic [2:0]  i_ls_rd_mask;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_ls_err_misaligned, o_ls_err_rdmask;
  logic [31:0] o_mem_address, o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] mem_rd_data = 32'd0;
  logic        mem_err_mis = 1'b0, mem_err_rdm = 1'b0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .i_ls_wr_mask(i_ls_wr_mask), .i_ls_rd_mask(i_ls_rd_mask), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_ls_err_misaligned(o_ls_err_misaligned), .o_ls_err_rdmask(o_ls_err_rdmask),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(mem_rd_data), .i_mem_err_misaligned(mem_err_mis),
    .i_mem_err_rdmask(mem_err_rdm)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- Memory semantics shared by Memory and reference ----------
  function automatic logic is_misal(input logic [31:0] a, input logic [1:0] wm,
                                    input logic [2:0] rm);
    case (wm)
      2'd1: return 1'b0;
      2'd2: return a[0];
      2'd3: return a[1:0] != 2'd0;
      default: begin
        if (rm == 3'd0) return a[1:0] != 2'd0;
        if (rm == 3'd1 || rm == 3'd3) return a[0];
        return 1'b0;
      end
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] wm);
    return (wm == 2'd3) ? 4 : int'(wm);
  endfunction

  function automatic logic [31:0] mem_read(input logic [7:0] arr [64],
                                           input logic [31:0] a, input logic [1:0] wm,
                                           input logic [2:0] rm);
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    int base;
    if (wm != 2'd0 || rm > 3'd4 || is_misal(a, wm, rm)) return JUNK;
    base = int'(a[5:0]) & ~3;
    w = {arr[base+3], arr[base+2], arr[base+1], arr[base]};
    h = a[1] ? w[31:16] : w[15:0];
    b = w[8*a[1:0] +: 8];
    case (rm)
      3'd0: return w;
      3'd1: return {16'd0, h};
      3'd2: return {24'd0, b};
      3'd3: return {{16{h[15]}}, h};
      default: return {{24{b[7]}}, b};
    endcase
  endfunction

  // ---------------- Memory model (driven by the DUT) ----------
  logic [7:0] mem_arr [64];
  logic       mem_ready = 1'b0;

  // Registered Memory: 1-cycle read response, byte-lane writes, error flags.
  always @(posedge i_clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 64; k++) mem_arr[k] <= (k % 4 == 0) ? 8'(k / 4) : 8'd0;
      mem_ready <= 1'b1;
    end else begin
      mem_rd_data <= mem_read(mem_arr, o_mem_address, o_mem_wr_mask, o_mem_rd_mask);
      mem_err_mis <= is_misal(o_mem_address, o_mem_wr_mask, o_mem_rd_mask);
      mem_err_rdm <= (o_mem_wr_mask == 2'd0) && (o_mem_rd_mask > 3'd5);
      if (o_mem_wr_mask != 2'd0 && !is_misal(o_mem_address, o_mem_wr_mask, o_mem_rd_mask))
        for (int k = 0; k < 4; k++)
          if (k < nbytes(o_mem_wr_mask))
            mem_arr[(int'(o_mem_address[5:0]) + k) & 63] <= o_mem_wr_data[8*k +: 8];
    end
  end

  // ---------------- Reference state and checking ----------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0]  ref_arr [64];
  int          m_starve;
  logic        m_last_ls;
  logic        exp_if_rv, exp_ls_rv, exp_mis, exp_rdm;
  logic [31:0] exp_if_rd, exp_ls_rd;
  logic        m_ifg, m_lsg, obs_ifg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_starve  = 0;
    m_last_ls = 1'b0;
    exp_if_rv = 1'b0; exp_ls_rv = 1'b0; exp_mis = 1'b0; exp_rdm = 1'b0;
    exp_if_rd = 32'd0; exp_ls_rd = 32'd0;
  endtask

  // One clock cycle, entered and left at a negedge: check last cycle's responses,
  // drive the requests, check grants and Memory drive, advance the reference.
  task automatic step(input logic ifq, input logic [31:0] ifa, input logic lsq,
                      input logic [31:0] lsa, input logic [31:0] lsd,
                      input logic [1:0] wm, input logic [2:0] rm);
    logic [31:0] d;
    check("if_rvalid", 32'(o_if_rvalid), 32'(exp_if_rv));
    check("if_rdata", o_if_rdata, exp_if_rd);
    check("ls_rvalid", 32'(o_ls_rvalid), 32'(exp_ls_rv));
    check("ls_rdata", o_ls_rdata, exp_ls_rd);
    check("ls_err_mis", 32'(o_ls_err_misaligned), 32'(exp_mis));
    check("ls_err_rdm", 32'(o_ls_err_rdmask), 32'(exp_rdm));
    i_if_req = ifq; i_if_addr = ifa;
    i_ls_req = lsq; i_ls_addr = lsa; i_ls_wdata = lsd;
    i_ls_wr_mask = wm; i_ls_rd_mask = rm;
    #1;
`ifdef MEMARB_ROUND_ROBIN_EN
    if (ifq && lsq) begin m_ifg = m_last_ls; m_lsg = !m_last_ls; end
    else begin m_ifg = ifq; m_lsg = lsq; end
`else
    // IF has waited STARVE_LIMIT cycles: it takes the Memory; otherwise LS first.
    m_lsg = lsq && !(ifq && m_starve >= STARVE_LIMIT);
    m_ifg = ifq && !m_lsg;
`endif
    obs_ifg = o_if_gnt;
    check("if_gnt", 32'(o_if_gnt), 32'(m_ifg));
    check("ls_gnt", 32'(o_ls_gnt), 32'(m_lsg));
    check("double_gnt", 32'(o_if_gnt & o_ls_gnt), 32'd0);
    if (m_lsg) begin
      $display("[%0t] LS gnt addr=%h wdata=%h wm=%0d rm=%0d", $time, lsa, lsd, wm, rm);
      check("mem_addr", o_mem_address, lsa);
      check("mem_wdata", o_mem_wr_data, lsd);
      check("mem_wmask", 32'(o_mem_wr_mask), 32'(wm));
      check("mem_rmask", 32'(o_mem_rd_mask), 32'(rm));
    end else if (m_ifg) begin
      $display("[%0t] IF gnt addr=%h", $time, ifa);
      check("mem_addr", o_mem_address, ifa);
      check("mem_wmask", 32'(o_mem_wr_mask), 32'd0);
      check("mem_rmask", 32'(o_mem_rd_mask), 32'd0);
    end else begin
      check("idle_addr", o_mem_address, 32'd0);
      check("idle_wmask", 32'(o_mem_wr_mask), 32'd0);
      check("idle_rmask", 32'(o_mem_rd_mask), 32'd5);
    end
    // Expected responses for the next cycle.
    exp_if_rv = m_ifg;
    exp_if_rd = m_ifg ? mem_read(ref_arr, ifa, 2'd0, 3'd0) : 32'd0;
    exp_ls_rv = m_lsg;
    d = mem_read(ref_arr, lsa, wm, rm);
    exp_ls_rd = (m_lsg && rm != 3'd5) ? d : 32'd0;
    exp_mis   = m_lsg && is_misal(lsa, wm, rm);
    exp_rdm   = m_lsg && wm == 2'd0 && rm > 3'd5;
    if (m_lsg && wm != 2'd0 && !is_misal(lsa, wm, rm))
      for (int k = 0; k < nbytes(wm); k++) ref_arr[(int'(lsa[5:0]) + k) & 63] = lsd[8*k +: 8];
    m_starve = (ifq && !m_ifg) ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
    if (m_ifg) m_last_ls = 1'b0;
    else if (m_lsg) m_last_ls = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  seq;
    logic        if_pend, ls_pend;
    logic [31:0] if_a, ls_a, ls_d;
    logic [1:0]  ls_wm;
    logic [2:0]  ls_rm;
    for (int k = 0; k < 64; k++) ref_arr[k] = (k % 4 == 0) ? 8'(k / 4) : 8'd0;
    model_reset();
    // Reset with both requests high: grants must stay low, outputs idle.
    i_reset = 1'b1;
    i_if_req = 1'b1; i_if_addr = 32'h4;
    i_ls_req = 1'b1; i_ls_addr = 32'h8; i_ls_wdata = 32'h1; i_ls_wr_mask = 2'd3; i_ls_rd_mask = 3'd5;
    repeat (3) @(negedge i_clk);
    check("rst_if_gnt", 32'(o_if_gnt), 32'd0);
    check("rst_ls_gnt", 32'(o_ls_gnt), 32'd0);
    check("rst_if_rvalid", 32'(o_if_rvalid), 32'd0);
    check("rst_ls_rvalid", 32'(o_ls_rvalid), 32'd0);
    check("rst_if_rdata", o_if_rdata, 32'd0);
    check("rst_ls_rdata", o_ls_rdata, 32'd0);
    check("rst_err", 32'({o_ls_err_misaligned, o_ls_err_rdmask}), 32'd0);
    check("rst_mem_rmask", 32'(o_mem_rd_mask), 32'd5);
    check("rst_mem_wmask", 32'(o_mem_wr_mask), 32'd0);
    i_reset = 1'b0;
    idle();

    // IF alone, back-to-back word reads at 0x0 and 0x4.
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 2'd0, 3'd5);
    check("t1_rvalid0", 32'(o_if_rvalid), 32'd1);
    check("t1_rdata0", o_if_rdata, 32'd0);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0, 2'd0, 3'd5);
    check("t1_rdata1", o_if_rdata, 32'd1);
    idle();

    // LS store word then sign-extended byte load of the top byte.
    step(1'b0, 32'd0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd3, 3'd5);
    step(1'b0, 32'd0, 1'b1, 32'h13, 32'd0, 2'd0, 3'd4);
    check("t2_load_be", o_ls_rdata, 32'hFFFFFFDE);
    idle();

    // Misaligned halfword store reports the error on the LS port only.
    step(1'b0, 32'd0, 1'b1, 32'h5, 32'h1234, 2'd2, 3'd5);
    check("t4_rvalid", 32'(o_ls_rvalid), 32'd1);
    check("t4_err_mis", 32'(o_ls_err_misaligned), 32'd1);
    check("t4_if_rvalid", 32'(o_if_rvalid), 32'd0);
    idle();

    // Reset in the cycle after an IF grant drops that response.
    step(1'b1, 32'h8, 1'b0, 32'd0, 32'd0, 2'd0, 3'd5);
    i_reset = 1'b1;
    #1;
    check("t5_if_rvalid", 32'(o_if_rvalid), 32'd0);
    check("t5_if_rdata", o_if_rdata, 32'd0);
    check("t5_if_gnt", 32'(o_if_gnt), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();

    // Both requesting continuously from reset.
    seq = '0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 32'h20, 1'b1, 32'h24, 32'd0, 2'd0, 3'd0);
      seq[c] = obs_ifg;
    end
`ifdef MEMARB_ROUND_ROBIN_EN
    check("t6_rr_pattern", 32'(seq), 32'h2AA);
`else
    check("t3_starve_pattern", 32'(seq), 32'h210);
`endif
    idle();

    // Random traffic; each requester holds its request until granted.
    if_pend = 1'b0; ls_pend = 1'b0;
    if_a = 32'd0; ls_a = 32'd0; ls_d = 32'd0; ls_wm = 2'd0; ls_rm = 3'd5;
    for (int c = 0; c < 400; c++) begin
      if (!if_pend && $urandom_range(0, 9) < 6) begin
        if_pend = 1'b1;
        if_a = 32'($urandom_range(0, 15)) << 2;
      end
      if (!ls_pend && $urandom_range(0, 9) < 7) begin
        ls_pend = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          ls_wm = 2'($urandom_range(1, 3)); ls_rm = 3'd5;
        end else begin
          ls_wm = 2'd0; ls_rm = 3'($urandom_range(0, 6));
        end
        ls_a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
          if (ls_wm == 2'd3 || (ls_wm == 2'd0 && ls_rm == 3'd0)) ls_a[1:0] = 2'd0;
          else if (ls_wm == 2'd2 || ls_rm == 3'd1 || ls_rm == 3'd3) ls_a[0] = 1'b0;
        end
        ls_d = $urandom;
      end
      step(if_pend, if_a, ls_pend, ls_a, ls_d, ls_wm, ls_rm);
      if (m_ifg) if_pend = 1'b0;
      if (m_lsg) ls_pend = 1'b0;
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
